// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, registers the fetched word into IF/ID,
// and applies the redirect > stall > advance priority plus bubble insertion.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic [31:0] fetch_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (!stall_i) begin
      pc_d = pc_plus4;
    end
  end

  // A bubble overrides stall so a stalled slot can still be squashed.
  always_comb begin
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_cnt_d     = fetch_cnt_q;
    if (redirect_i || flush_i) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (!stall_i) begin
      ifid_pc_d       = pc_q;
      ifid_pc_plus4_d = pc_plus4;
      ifid_instr_d    = instr;
      ifid_valid_d    = 1'b1;
      fetch_cnt_d     = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q            <= RESET_PC;
      ifid_pc_q       <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_instr_q    <= NOP_INSTR;
      ifid_valid_q    <= 1'b0;
      fetch_cnt_q     <= '0;
    end else begin
      pc_q            <= pc_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_valid_q    <= ifid_valid_d;
      fetch_cnt_q     <= fetch_cnt_d;
    end
  end

  assign pc            = pc_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_valid    = ifid_valid_q;
  assign fetch_cnt     = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a combinational instruction-memory model.
`timescale 1ns/1ps
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [31:0] fetch_cnt;

  int unsigned checks;
  int unsigned errors;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_i   (redirect_i),
    .redirect_pc  (redirect_pc),
    .pc           (pc),
    .instr        (instr),
    .ifid_pc      (ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_instr   (ifid_instr),
    .ifid_valid   (ifid_valid),
    .fetch_cnt    (fetch_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0050_0093;
    return 32'hA500_0000 ^ addr;
  endfunction

  always_comb instr = mem_word(pc);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] e_pc,
                              input logic [31:0] e_ipc, input logic [31:0] e_instr,
                              input logic e_valid, input logic [31:0] e_cnt);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".ifid_pc"}, ifid_pc, e_ipc);
    check({tag, ".ifid_pc_plus4"}, ifid_pc_plus4, (e_ipc == 32'h0 && e_cnt == 32'h0) ? 32'h0 : e_ipc + 32'd4);
    check({tag, ".ifid_instr"}, ifid_instr, e_instr);
    check({tag, ".ifid_valid"}, {31'h0, ifid_valid}, {31'h0, e_valid});
    check({tag, ".fetch_cnt"}, fetch_cnt, e_cnt);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc = '0;

    repeat (3) tick();
    expect_state("reset", 32'h0, 32'h0, NOP, 1'b0, 32'd0);
    rst_n = 1'b1;

    tick();
    expect_state("first", 32'h4, 32'h0, 32'h0050_0093, 1'b1, 32'd1);
    tick();
    expect_state("seq1", 32'h8, 32'h4, mem_word(32'h4), 1'b1, 32'd2);

    stall_i = 1'b1;
    tick();
    expect_state("stall1", 32'h8, 32'h4, mem_word(32'h4), 1'b1, 32'd2);
    tick();
    expect_state("stall2", 32'h8, 32'h4, mem_word(32'h4), 1'b1, 32'd2);
    stall_i = 1'b0;
    tick();
    expect_state("unstall", 32'hC, 32'h8, mem_word(32'h8), 1'b1, 32'd3);

    redirect_i = 1'b1;
    redirect_pc = 32'h0000_0043;
    tick();
    expect_state("redir", 32'h40, 32'h8, NOP, 1'b0, 32'd3);
    redirect_i = 1'b0;
    tick();
    expect_state("post_redir", 32'h44, 32'h40, mem_word(32'h40), 1'b1, 32'd4);
    tick();
    expect_state("seq2", 32'h48, 32'h44, mem_word(32'h44), 1'b1, 32'd5);

    redirect_i = 1'b1;
    redirect_pc = 32'h0000_0010;
    tick();
    expect_state("redir16", 32'h10, 32'h44, NOP, 1'b0, 32'd5);
    redirect_i = 1'b0;
    stall_i = 1'b1;
    flush_i = 1'b1;
    tick();
    expect_state("stall_flush", 32'h10, 32'h44, NOP, 1'b0, 32'd5);
    flush_i = 1'b0;
    redirect_i = 1'b1;
    redirect_pc = 32'h0000_0020;
    tick();
    expect_state("redir_stall", 32'h20, 32'h44, NOP, 1'b0, 32'd5);
    redirect_i = 1'b0;
    stall_i = 1'b0;
    tick();
    expect_state("post_rs", 32'h24, 32'h20, mem_word(32'h20), 1'b1, 32'd6);

    flush_i = 1'b1;
    tick();
    expect_state("flush", 32'h28, 32'h20, NOP, 1'b0, 32'd6);
    flush_i = 1'b0;
    tick();
    expect_state("post_flush", 32'h2C, 32'h28, mem_word(32'h28), 1'b1, 32'd7);

    redirect_i = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    expect_state("redir_top", 32'hFFFF_FFFC, 32'h28, NOP, 1'b0, 32'd7);
    redirect_i = 1'b0;
    tick();
    check("wrap.pc", pc, 32'h0);
    check("wrap.ifid_pc", ifid_pc, 32'hFFFF_FFFC);
    check("wrap.ifid_pc_plus4", ifid_pc_plus4, 32'h0);
    check("wrap.ifid_instr", ifid_instr, mem_word(32'hFFFF_FFFC));
    check("wrap.fetch_cnt", fetch_cnt, 32'd8);

    redirect_i = 1'b1;
    redirect_pc = 32'h0000_0100;
    #2;
    rst_n = 1'b0;
    #1;
    expect_state("async_rst", 32'h0, 32'h0, NOP, 1'b0, 32'd0);
    tick();
    expect_state("rst_held", 32'h0, 32'h0, NOP, 1'b0, 32'd0);
    redirect_i = 1'b0;
    rst_n = 1'b1;
    tick();
    expect_state("after_rst", 32'h4, 32'h0, 32'h0050_0093, 1'b1, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined RISC-V core.
- Owns the program counter and drives the fetch address to the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register with a valid bit.
- Handles stall (hazard unit), flush, and taken-branch/jump redirect from EX, and keeps a retired-fetch counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, word placed in ifid_instr for a bubble (addi x0,x0,0).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall_i  input  1  hold PC and IF/ID contents (load-use hazard).
- flush_i  input  1  replace the next IF/ID contents with a bubble.
- redirect_i  input  1  taken branch/jump resolved in EX.
- redirect_pc  input  32  target address for redirect_i.
- pc  output  32  fetch address to instruction memory; equals the internal PC register.
- instr  input  32  instruction word from instruction memory, valid in the same cycle as pc.
- ifid_pc  output  32  PC of the instruction held in IF/ID.
- ifid_pc_plus4  output  32  ifid_pc + 4, used for JAL/JALR link.
- ifid_instr  output  32  instruction held in IF/ID.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- fetch_cnt  output  32  count of valid instructions latched into IF/ID.

Behaviour:
- Reset, asynchronous on rst_n low and held while low:
  - pc = RESET_PC.
  - ifid_pc = 0, ifid_pc_plus4 = 0.
  - ifid_instr = NOP_INSTR, ifid_valid = 0.
  - fetch_cnt = 0.
- First edge after reset release: IF/ID captures the instruction at RESET_PC, and pc becomes RESET_PC+4.
- Latency: an instruction presented on instr in cycle N appears on ifid_* after edge N+1.
- Per-edge priority, highest first: redirect_i > stall_i > normal advance. flush_i only affects IF/ID.
- PC update:
  - redirect_i=1: pc <= {redirect_pc[31:2], 2'b00}. Low two bits are forced to zero; no misalignment trap is raised in this block.
  - else stall_i=1: pc holds.
  - else: pc <= pc + 4. The add is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.
- IF/ID update:
  - redirect_i=1 or flush_i=1: bubble. ifid_valid <= 0, ifid_instr <= NOP_INSTR, ifid_pc and ifid_pc_plus4 hold. This takes effect even when stall_i=1.
  - else stall_i=1: all ifid_* hold.
  - else: ifid_pc <= pc, ifid_pc_plus4 <= pc+4, ifid_instr <= instr, ifid_valid <= 1.
- Simultaneous stall_i=1 and flush_i=1 (no redirect): pc holds and IF/ID becomes a bubble. The held pc refetches the same instruction next cycle, so nothing is lost.
- Simultaneous redirect_i and stall_i: redirect wins. pc loads the target and IF/ID becomes a bubble.
- fetch_cnt increments by 1 on each edge where IF/ID loads with ifid_valid <= 1. It wraps modulo 2^32 and never increments on bubble or hold edges.
- No combinational path from the stall_i, flush_i or redirect_i inputs to any output. pc and all ifid_* are registered.
- Reset asserted mid-operation: every register returns to its reset value immediately, without waiting for clk. A redirect in progress is discarded.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, drive instr=32'h00500093, then release → pc=0, ifid_valid=0 and ifid_instr=32'h00000013 during reset; after the first edge ifid_pc=0, ifid_instr=32'h00500093, ifid_valid=1, pc=4, fetch_cnt=1.
- Sequential fetch: 5 free-running cycles with the memory model returning distinct words → pc steps 0,4,8,12,16,20; ifid_pc lags pc by one edge; fetch_cnt=5.
- Stall: at pc=8, assert stall_i for 2 cycles → pc stays 8 and ifid_* unchanged for 2 edges; on release ifid_pc=8 and fetch_cnt increments once.
- Redirect: at pc=12, redirect_i=1 with redirect_pc=32'h0000_0043 → next pc=32'h40, ifid_valid=0 with NOP_INSTR; the following edge gives ifid_pc=32'h40, ifid_valid=1.
- Flush+stall and redirect+stall together: stall_i=flush_i=1 at pc=16 → pc=16 and a bubble. Then redirect_i=stall_i=1 with redirect_pc=32'h20 → pc=32'h20, bubble, fetch_cnt unchanged on both edges.
- Wrap and async reset: redirect to 32'hFFFF_FFFC and advance → pc=0 and ifid_pc=32'hFFFF_FFFC. Drop rst_n mid-cycle → all outputs take reset values before the next clk edge.
